// File: rtl/spi_master_fifo.sv
// SPI master with CPU register window, TX/RX FIFOs and a programmable shift engine.
// Full-duplex frames are MSB first, with selectable CPOL/CPHA and an SCLK divider.
module spi_master_fifo #(
    parameter int W_CPU      = 32,
    parameter int W_DATA     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int W_DIV      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_wr,
    input  logic              cpu_rd,
    input  logic [1:0]        cpu_addr,
    input  logic [W_CPU-1:0]  cpu_wdata,
    output logic [W_CPU-1:0]  cpu_rdata,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic              cs_n,
    output logic              irq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = $clog2(2 * W_DATA);
    localparam int CW = W_DIV + 4;
    localparam logic [EW-1:0]    LAST_EDGE = EW'(2 * W_DATA - 1);
    localparam logic [EW-1:0]    EDGE_ONE  = EW'(1);
    localparam logic [W_DIV-1:0] DIV_ONE   = W_DIV'(1);
    localparam logic [AW:0]      PTR_ONE   = (AW + 1)'(1);
    localparam logic [1:0] A_TX = 2'd0, A_RX = 2'd1, A_STATUS = 2'd2, A_CTRL = 2'd3;

    typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_t;
    state_t state, state_next;

    logic [CW-1:0]     ctrl;
    logic              ctrl_en, ctrl_cpol, ctrl_cpha, ctrl_irq_en;
    logic [W_DIV-1:0]  ctrl_div;

    logic [W_DATA-1:0] tx_mem [FIFO_DEPTH];
    logic [W_DATA-1:0] rx_mem [FIFO_DEPTH];
    logic [AW:0]       tx_wp, tx_rp, rx_wp, rx_rp;
    logic              tx_empty, tx_full, rx_empty, rx_full;
    logic              tx_ovf, rx_ovf;
    logic [6:0]        status;
    logic [W_CPU-1:0]  rd_mux;

    logic              wr_tx, wr_status, tx_push, tx_drop, rx_pop, rx_write, rx_drop;
    logic              load, rx_push, cnt_done;
    logic [W_DIV-1:0]  cnt, div_q;
    logic [EW-1:0]     edge_cnt;
    logic              cpha_q;
    logic [W_DATA-1:0] tx_sr, rx_sr, tx_shift, rx_shift, tx_head;
    logic              unused_wdata;

    assign ctrl_en     = ctrl[0];
    assign ctrl_cpol   = ctrl[1];
    assign ctrl_cpha   = ctrl[2];
    assign ctrl_irq_en = ctrl[3];
    assign ctrl_div    = ctrl[CW-1:4];

    assign tx_empty = (tx_wp == tx_rp);
    assign tx_full  = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
    assign rx_empty = (rx_wp == rx_rp);
    assign rx_full  = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
    assign tx_head  = tx_mem[tx_rp[AW-1:0]];

    assign wr_tx     = cpu_wr && (cpu_addr == A_TX);
    assign wr_status = cpu_wr && (cpu_addr == A_STATUS);
    assign tx_push   = wr_tx && !tx_full;
    assign tx_drop   = wr_tx && tx_full;
    assign rx_pop    = cpu_rd && (cpu_addr == A_RX) && !rx_empty;
    assign rx_write  = rx_push && !rx_full;
    assign rx_drop   = rx_push && rx_full;

    assign status = {tx_ovf, rx_ovf, rx_full, rx_empty, tx_full, tx_empty, (state != IDLE)};
    assign irq    = ctrl_irq_en & (!rx_empty | rx_ovf | tx_ovf);
    assign cnt_done = (cnt == div_q);
    assign unused_wdata = ^cpu_wdata;

    always_comb begin
        rd_mux = '0;
        case (cpu_addr)
            A_RX:     if (!rx_empty) rd_mux[W_DATA-1:0] = rx_mem[rx_rp[AW-1:0]];
            A_STATUS: rd_mux[6:0] = status;
            A_CTRL:   rd_mux[CW-1:0] = ctrl;
            default:  rd_mux = '0;
        endcase
    end

    always_comb begin
        tx_shift    = tx_sr << 1;
        rx_shift    = rx_sr << 1;
        rx_shift[0] = miso;
    end

    // FIFO storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp[AW-1:0]] <= cpu_wdata[W_DATA-1:0];
        if (rx_write) rx_mem[rx_wp[AW-1:0]] <= rx_sr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wp     <= '0;
            tx_rp     <= '0;
            rx_wp     <= '0;
            rx_rp     <= '0;
            tx_ovf    <= 1'b0;
            rx_ovf    <= 1'b0;
            ctrl      <= '0;
            cpu_rdata <= '0;
        end else begin
            if (tx_push)  tx_wp <= tx_wp + PTR_ONE;
            if (load)     tx_rp <= tx_rp + PTR_ONE;
            if (rx_write) rx_wp <= rx_wp + PTR_ONE;
            if (rx_pop)   rx_rp <= rx_rp + PTR_ONE;
            // A new overflow in the same cycle as a clear wins, so no event is lost.
            tx_ovf <= tx_drop | (tx_ovf & ~(wr_status & cpu_wdata[6]));
            rx_ovf <= rx_drop | (rx_ovf & ~(wr_status & cpu_wdata[5]));
            if (cpu_wr && (cpu_addr == A_CTRL)) ctrl <= cpu_wdata[CW-1:0];
            if (cpu_rd) cpu_rdata <= rd_mux;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        rx_push    = 1'b0;
        case (state)
            IDLE: begin
                if (ctrl_en && !tx_empty) begin
                    load       = 1'b1;
                    state_next = LEAD;
                end
            end
            LEAD:  if (cnt_done) state_next = SHIFT;
            SHIFT: if (cnt_done && (edge_cnt == LAST_EDGE)) state_next = TRAIL;
            TRAIL: begin
                if (cnt_done) begin
                    rx_push = 1'b1;
                    if (tx_empty || !ctrl_en) begin
                        state_next = IDLE;
                    end else begin
                        load       = 1'b1;
                        state_next = LEAD;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Sample on the edge whose parity matches cpha, shift out on the other one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            edge_cnt <= '0;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            cs_n     <= 1'b1;
            tx_sr    <= '0;
            rx_sr    <= '0;
            div_q    <= '0;
            cpha_q   <= 1'b0;
        end else if (load) begin
            cnt      <= '0;
            edge_cnt <= '0;
            sclk     <= ctrl_cpol;
            mosi     <= tx_head[W_DATA-1];
            cs_n     <= 1'b0;
            tx_sr    <= tx_head;
            div_q    <= ctrl_div;
            cpha_q   <= ctrl_cpha;
        end else begin
            case (state)
                IDLE: sclk <= ctrl_cpol;
                LEAD: cnt <= cnt_done ? '0 : cnt + DIV_ONE;
                SHIFT: begin
                    if (cnt_done) begin
                        cnt      <= '0;
                        edge_cnt <= edge_cnt + EDGE_ONE;
                        sclk     <= ~sclk;
                        if (edge_cnt[0] == cpha_q) begin
                            rx_sr <= rx_shift;
                        end else begin
                            tx_sr <= tx_shift;
                            mosi  <= cpha_q ? tx_sr[W_DATA-1] : tx_shift[W_DATA-1];
                        end
                    end else begin
                        cnt <= cnt + DIV_ONE;
                    end
                end
                TRAIL: begin
                    cnt <= cnt_done ? '0 : cnt + DIV_ONE;
                    if (cnt_done && (state_next == IDLE)) cs_n <= 1'b1;
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_fifo.sv
// Directed testbench for spi_master_fifo: MISO is looped back from MOSI so each
// received word must equal the word that was sent.
module tb_spi_master_fifo;

    localparam logic [1:0] A_TX = 2'd0, A_RX = 2'd1, A_STATUS = 2'd2, A_CTRL = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_wr, cpu_rd;
    logic [1:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        sclk, mosi, cs_n, irq;
    logic        miso;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    assign miso = mosi;

    spi_master_fifo #(.W_CPU(32), .W_DATA(8), .FIFO_DEPTH(4), .W_DIV(8)) dut (
        .clk(clk), .rst(rst), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .sclk(sclk), .mosi(mosi),
        .miso(miso), .cs_n(cs_n), .irq(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        cpu_addr = a; cpu_wdata = d; cpu_wr = 1'b1;
        tick();
        cpu_wr = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        cpu_addr = a; cpu_rd = 1'b1;
        tick();
        cpu_rd = 1'b0;
        d = cpu_rdata;
    endtask

    task automatic wait_cs(input logic level, input int bound, output logic ok, output int at);
        int n;
        n = 0;
        while (cs_n !== level && n < bound) begin
            tick();
            n++;
        end
        ok = (cs_n === level);
        at = cyc;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1; cpu_wr = 1'b0; cpu_rd = 1'b0; cpu_addr = 2'd0; cpu_wdata = '0;
        repeat (3) tick();
        checks++;
        if ({cs_n, sclk, mosi, irq} !== 4'b1000) begin
            errors++; $display("[TB] FAIL reset_pins: got %b expected 1000", {cs_n, sclk, mosi, irq});
        end
        checks++;
        if (cpu_rdata !== 32'h0) begin
            errors++; $display("[TB] FAIL reset_rdata: got %h expected 0", cpu_rdata);
        end
        rst = 1'b0;
        tick();
        bus_read(A_STATUS, d);
        checks++;
        if (d !== 32'h0A) begin errors++; $display("[TB] FAIL reset_status: got %h expected 0a", d); end
        bus_read(A_CTRL, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("[TB] FAIL reset_ctrl: got %h expected 0", d); end
    endtask

    // Mode 0, div=1: 36 clocks with cs_n low, first SCLK rise 4 clocks in, 2-clock halves.
    task automatic test_mode0();
        logic [31:0] d;
        logic ok, prev;
        int at, low, toggles, first, last, bad_gap;
        bus_write(A_CTRL, 32'h11);
        bus_write(A_TX, 32'hA5);
        wait_cs(1'b0, 20, ok, at);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL m0_start: cs_n=%b expected 0", cs_n); end
        checks++;
        if (mosi !== 1'b1) begin errors++; $display("[TB] FAIL m0_msb: mosi=%b expected 1", mosi); end
        low = 0; toggles = 0; first = -1; last = 0; bad_gap = 0; prev = sclk;
        while (cs_n === 1'b0 && low < 100) begin
            low++;
            tick();
            if (sclk !== prev) begin
                toggles++;
                if (first < 0) first = low;
                else if (low - last != 2) bad_gap++;
                last = low;
                prev = sclk;
            end
        end
        checks++;
        if (low != 36) begin errors++; $display("[TB] FAIL m0_frame_len: got %0d expected 36", low); end
        checks++;
        if (toggles != 16) begin errors++; $display("[TB] FAIL m0_edges: got %0d expected 16", toggles); end
        checks++;
        if (first != 4) begin errors++; $display("[TB] FAIL m0_first_edge: got %0d expected 4", first); end
        checks++;
        if (bad_gap != 0) begin errors++; $display("[TB] FAIL m0_half_period: got %0d bad gaps expected 0", bad_gap); end
        bus_read(A_RX, d);
        checks++;
        if (d !== 32'hA5) begin errors++; $display("[TB] FAIL m0_rx: got %h expected a5", d); end
        bus_read(A_STATUS, d);
        checks++;
        if (d !== 32'h0A) begin errors++; $display("[TB] FAIL m0_status: got %h expected 0a", d); end
    endtask

    // Mode 3 back-to-back: two frames with cs_n low throughout, SCLK idling high.
    task automatic test_back_to_back();
        logic [31:0] d;
        logic ok;
        int at, low;
        bus_write(A_CTRL, 32'h17);
        tick();
        checks++;
        if (sclk !== 1'b1) begin errors++; $display("[TB] FAIL m3_idle_sclk: got %b expected 1", sclk); end
        bus_write(A_TX, 32'h3C);
        bus_write(A_TX, 32'hC3);
        wait_cs(1'b0, 20, ok, at);
        checks++;
        if (!ok || sclk !== 1'b1) begin
            errors++; $display("[TB] FAIL m3_start: cs_n=%b sclk=%b expected 0 1", cs_n, sclk);
        end
        low = 0;
        while (cs_n === 1'b0 && low < 200) begin
            low++;
            tick();
        end
        checks++;
        if (low != 72) begin errors++; $display("[TB] FAIL m3_cs_low: got %0d expected 72", low); end
        checks++;
        if (sclk !== 1'b1) begin errors++; $display("[TB] FAIL m3_end_sclk: got %b expected 1", sclk); end
        bus_read(A_RX, d);
        checks++;
        if (d !== 32'h3C) begin errors++; $display("[TB] FAIL m3_rx0: got %h expected 3c", d); end
        bus_read(A_RX, d);
        checks++;
        if (d !== 32'hC3) begin errors++; $display("[TB] FAIL m3_rx1: got %h expected c3", d); end
        bus_write(A_CTRL, 32'h0);
        tick();
    endtask

    task automatic test_tx_overflow();
        logic [31:0] d;
        for (int i = 0; i < 5; i++) bus_write(A_TX, 32'h11 + i);
        bus_read(A_STATUS, d);
        checks++;
        if (d !== 32'h4C) begin errors++; $display("[TB] FAIL txovf_status: got %h expected 4c", d); end
        bus_write(A_STATUS, 32'h40);
        bus_read(A_STATUS, d);
        checks++;
        if (d !== 32'h0C) begin errors++; $display("[TB] FAIL txovf_clear: got %h expected 0c", d); end
    endtask

    // Four queued words plus one more give five div=0 frames (18 clk each); the fifth is dropped.
    task automatic test_rx_overflow();
        logic [31:0] d;
        logic ok;
        int t0, t1;
        bus_write(A_CTRL, 32'h09);
        wait_cs(1'b0, 20, ok, t0);
        bus_write(A_TX, 32'h5A);
        wait_cs(1'b1, 200, ok, t1);
        checks++;
        if (!ok || t1 - t0 != 90) begin
            errors++; $display("[TB] FAIL rxovf_len: got %0d ok=%b expected 90", t1 - t0, ok);
        end
        bus_read(A_STATUS, d);
        checks++;
        if (d !== 32'h32) begin errors++; $display("[TB] FAIL rxovf_status: got %h expected 32", d); end
        checks++;
        if (irq !== 1'b1) begin errors++; $display("[TB] FAIL rxovf_irq: got %b expected 1", irq); end
        for (int i = 0; i < 4; i++) begin
            bus_read(A_RX, d);
            checks++;
            if (d !== 32'h11 + i) begin
                errors++; $display("[TB] FAIL rxovf_data%0d: got %h expected %h", i, d, 32'h11 + i);
            end
        end
        bus_read(A_STATUS, d);
        checks++;
        if (d !== 32'h2A || irq !== 1'b1) begin
            errors++; $display("[TB] FAIL rxovf_sticky: got %h irq %b expected 2a irq 1", d, irq);
        end
        bus_write(A_STATUS, 32'h20);
        bus_read(A_STATUS, d);
        checks++;
        if (d !== 32'h0A || irq !== 1'b0) begin
            errors++; $display("[TB] FAIL rxovf_clear: got %h irq %b expected 0a irq 0", d, irq);
        end
    endtask

    task automatic test_empty_read_and_disable();
        logic [31:0] d;
        logic ok;
        int t0, t1;
        bus_read(A_CTRL, d);
        bus_read(A_RX, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("[TB] FAIL empty_rd: got %h expected 0", d); end
        bus_read(A_STATUS, d);
        checks++;
        if (d !== 32'h0A) begin errors++; $display("[TB] FAIL empty_status: got %h expected 0a", d); end
        bus_write(A_CTRL, 32'h11);
        bus_write(A_TX, 32'h96);
        bus_write(A_TX, 32'h69);
        wait_cs(1'b0, 20, ok, t0);
        repeat (10) tick();
        bus_write(A_CTRL, 32'h10);
        wait_cs(1'b1, 100, ok, t1);
        checks++;
        if (!ok || t1 - t0 != 36) begin
            errors++; $display("[TB] FAIL dis_len: got %0d ok=%b expected 36", t1 - t0, ok);
        end
        repeat (40) tick();
        checks++;
        if (cs_n !== 1'b1) begin errors++; $display("[TB] FAIL dis_idle: cs_n=%b expected 1", cs_n); end
        bus_read(A_STATUS, d);
        checks++;
        if (d !== 32'h00) begin errors++; $display("[TB] FAIL dis_status: got %h expected 00", d); end
        bus_read(A_RX, d);
        checks++;
        if (d !== 32'h96) begin errors++; $display("[TB] FAIL dis_rx: got %h expected 96", d); end
    endtask

    // The leftover 0x69 completes, then 0x42 is cut short by an asynchronous reset.
    task automatic test_reset_mid_frame();
        logic [31:0] d;
        logic ok;
        int at;
        bus_write(A_CTRL, 32'h1B);
        wait_cs(1'b0, 20, ok, at);
        wait_cs(1'b1, 100, ok, at);
        checks++;
        if (!ok || irq !== 1'b1) begin
            errors++; $display("[TB] FAIL mid_pre_irq: irq=%b ok=%b expected 1 1", irq, ok);
        end
        bus_write(A_TX, 32'h42);
        wait_cs(1'b0, 20, ok, at);
        repeat (8) tick();
        bus_read(A_CTRL, d);
        checks++;
        if (d !== 32'h1B || cs_n !== 1'b0) begin
            errors++; $display("[TB] FAIL mid_pre: rdata %h cs_n %b expected 1b 0", d, cs_n);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({cs_n, sclk, mosi, irq} !== 4'b1000) begin
            errors++; $display("[TB] FAIL mid_pins: got %b expected 1000", {cs_n, sclk, mosi, irq});
        end
        checks++;
        if (cpu_rdata !== 32'h0) begin errors++; $display("[TB] FAIL mid_rdata: got %h expected 0", cpu_rdata); end
        tick();
        rst = 1'b0;
        bus_read(A_STATUS, d);
        checks++;
        if (d !== 32'h0A) begin errors++; $display("[TB] FAIL mid_status: got %h expected 0a", d); end
        repeat (20) tick();
        checks++;
        if (cs_n !== 1'b1) begin errors++; $display("[TB] FAIL mid_idle: cs_n=%b expected 1", cs_n); end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_back_to_back();
        test_tx_overflow();
        test_rx_overflow();
        test_empty_read_and_disable();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
